bus_phase_responder: RTL
========================

// Module: bus_phase_responder
// PURPOSE
//  Memory-side end of the 6502 core's multiplexed bus. The core time-multiplexes its pins by phase:
//  - phase=1: address low byte on the address lane, flag byte on the data lane (flag bit RW_BIT: 0=read, 1=write).
//  - phase=0: address high byte on the address lane, write data on the data lane.
//  This block rebuilds the 16-bit address and RW, runs a req/ready handshake to a memory/peripheral
//  port, and returns read data for the core to sample. It sits between the core pins and board memory/ROM.
// PARAMETERS
//  TIMEOUT_CYCLES  16     clk cycles in REQ without mem_ready before abort (>=2)
//  FILL_BYTE       8'hEA  data returned on timeout/abort (NOP opcode)
//  RW_BIT          0      bit index of RW inside the flag byte
// PORTS
//  clk          in   1   single clock; all state on posedge clk
//  rst          in   1   asynchronous reset, active-high
//  phase        in   1   bus phase from core (1 = low/flag phase, 0 = high/data phase)
//  addr_lane    in   8   core address lane (lo byte when phase=1, hi byte when phase=0)
//  data_lane    in   8   core data lane (flags when phase=1, write data when phase=0)
//  rdata_out    out  8   read data back to core
//  rdata_oe     out  1   1 = rdata_out valid/driven
//  mem_addr     out  16  reconstructed address
//  mem_wdata    out  8   write data
//  mem_we       out  1   1 = write request, 0 = read; valid while mem_req=1
//  mem_req      out  1   request; held high until mem_ready or abort
//  mem_ready    in   1   memory completes request this cycle
//  mem_rdata    in   8   read data, valid when mem_ready=1 and mem_we=0
//  err          out  1   one-cycle pulse on timeout or protocol violation
//  err_count    out  8   saturating error count (stops at 8'hFF)
// BEHAVIOUR
//  Reset (async): state=IDLE; phase_q=1; all outputs 0; err_count=0; internal regs 0.
//  phase is sampled into phase_q each clk; rise = phase & ~phase_q; fall = ~phase & phase_q.
//  FSM states IDLE, HI_WAIT, REQ, RESP:
//  - IDLE: on rise, latch addr_lo<=addr_lane and rw<=data_lane[RW_BIT], go HI_WAIT.
//  - HI_WAIT: on fall, latch addr_hi<=addr_lane and wdata<=data_lane, go REQ.
//    Next cycle mem_req=1, mem_addr={addr_hi,addr_lo}, mem_we=rw, mem_wdata=wdata.
//  - REQ: mem_req/mem_addr/mem_we/mem_wdata held stable; timeout counter increments each cycle.
//    On mem_ready: drop mem_req next cycle; if read, rdata_q<=mem_rdata; go RESP.
//    Latency: fall edge to mem_req = 1 cycle; mem_ready to rdata_oe = 1 cycle.
//  - RESP: rdata_out=rdata_q; rdata_oe=1 only for reads (0 for writes). On rise, treat exactly as
//    IDLE rise (capture lo/flags, go HI_WAIT) and drop rdata_oe in the same edge.
//  - Timeout: counter reaches TIMEOUT_CYCLES in REQ -> mem_req=0, err pulse, rdata_q=FILL_BYTE,
//    go RESP (rdata_oe=1 only if read). Counter clears on entry to REQ.
//  - Protocol violation: rise in HI_WAIT or REQ -> abort (mem_req=0), err pulse, rdata_oe=0,
//    capture the new lo/flags, go HI_WAIT. Rise wins over mem_ready in the same cycle; the
//    memory must tolerate a dropped request.
//  - fall in IDLE or RESP: ignored.
//  - err_count increments once per err pulse and saturates at 8'hFF. Cleared only by rst.
//  - rst mid-transaction: immediate return to reset values; mem_req drops asynchronously.
//  - mem_ready outside REQ: ignored.
// TESTING
//  1 Read: rise lo=34 flags=00, fall hi=12 -> mem_req=1, addr=1234, we=0; ready with rdata=A9 -> next cycle rdata_out=A9, oe=1.
//  2 Write: rise lo=FF flags=01, fall hi=00 data=5A -> mem_req, addr=00FF, we=1, wdata=5A; after ready, oe stays 0.
//  3 Timeout: read to FFFC, mem_ready held 0 -> mem_req low after 16 REQ cycles; err pulse; rdata_out=EA; err_count=1.
//  4 Violation: second rise while in REQ -> mem_req drops, err pulses, new lo captured; next fall starts a clean request.
//  5 Saturation: force 300 timeouts -> err_count holds FF.
//  6 Async reset asserted during REQ (between clk edges) -> mem_req, rdata_oe, err_count go 0 immediately; state IDLE.

Source files
------------

// File: rtl/bus_phase_responder.sv
// Memory-side responder for the phase-multiplexed 6502 bus: rebuilds address/RW from the
// two bus phases, runs a req/ready handshake to memory and returns read data to the core.
module bus_phase_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  FILL_BYTE      = 8'hEA,
    parameter int unsigned RW_BIT         = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phase,
    input  logic [7:0]  addr_lane,
    input  logic [7:0]  data_lane,
    output logic [7:0]  rdata_out,
    output logic        rdata_oe,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HI_WAIT, REQ, RESP} state_t;

    state_t        state_q, state_d;
    logic          phase_q;
    logic [7:0]    addr_lo_q, addr_lo_d;
    logic [7:0]    addr_hi_q, addr_hi_d;
    logic          rw_q, rw_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          req_q, req_d;
    logic          oe_q, oe_d;
    logic          err_q, err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic rise, fall;
    assign rise = phase & ~phase_q;
    assign fall = ~phase & phase_q;

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        addr_hi_d   = addr_hi_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        req_d       = req_q;
        oe_d        = oe_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE, RESP: begin
                if (rise) begin
                    addr_lo_d = addr_lane;
                    rw_d      = data_lane[RW_BIT];
                    oe_d      = 1'b0;
                    state_d   = HI_WAIT;
                end
            end
            HI_WAIT: begin
                if (rise) begin
                    err_d     = 1'b1;
                    addr_lo_d = addr_lane;
                    rw_d      = data_lane[RW_BIT];
                end else if (fall) begin
                    addr_hi_d = addr_lane;
                    wdata_d   = data_lane;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // A new low phase mid-request aborts it; this outranks mem_ready.
                if (rise) begin
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    oe_d      = 1'b0;
                    addr_lo_d = addr_lane;
                    rw_d      = data_lane[RW_BIT];
                    state_d   = HI_WAIT;
                end else if (mem_ready) begin
                    req_d   = 1'b0;
                    oe_d    = ~rw_q;
                    if (!rw_q) rdata_d = mem_rdata;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = FILL_BYTE;
                    oe_d    = ~rw_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        err_count_d = (err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b1;
            addr_lo_q   <= '0;
            addr_hi_q   <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            req_q       <= 1'b0;
            oe_q        <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase;
            addr_lo_q   <= addr_lo_d;
            addr_hi_q   <= addr_hi_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            req_q       <= req_d;
            oe_q        <= oe_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rdata_out = rdata_q;
    assign rdata_oe  = oe_q;
    assign mem_addr  = {addr_hi_q, addr_lo_q};
    assign mem_wdata = wdata_q;
    assign mem_we    = rw_q;
    assign mem_req   = req_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
